// File: rtl/mac_sequencer_if.sv
// ---------------------------------------------------------------------------
// mac_sequencer_if : control/data bundle between ROM-MAC datapath and its sequencer (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

interface mac_sequencer_if #(
   parameter int LANES  = 16,
   parameter int A_AW   = 12,
   parameter int B_AW   = 6,
   parameter int PROD_W = 16,
   parameter int ACC_W  = 16
);
   logic                    start;
   logic                    abort;
   logic [LANES*PROD_W-1:0] products;
   logic [LANES*A_AW-1:0]   a_addr;
   logic [LANES*B_AW-1:0]   b_addr;
   logic                    busy;
   logic                    done;
   logic [ACC_W-1:0]        result;
   logic                    ovf;
   logic [15:0]             cycles;

   modport master (
      output start, abort, products,
      input  a_addr, b_addr, busy, done, result, ovf, cycles
   );

   modport slave (
      input  start, abort, products,
      output a_addr, b_addr, busy, done, result, ovf, cycles
   );
endinterface

`default_nettype wire

// File: rtl/mac_sequencer.sv
// ---------------------------------------------------------------------------
// mac_sequencer : restartable ROM address sequencer with lane-sum accumulator (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

module mac_sequencer #(
   parameter int LANES   = 16,
   parameter int A_AW    = 12,
   parameter int B_AW    = 6,
   parameter int PROD_W  = 16,
   parameter int ACC_W   = 16,
   parameter int ROM_LAT = 1
) (
   input  logic             clock,
   input  logic             reset_l,
   mac_sequencer_if.slave   bus
);

   localparam int LANE_W = $clog2(LANES);
   localparam int BEAT_W = A_AW - LANE_W;
   localparam int SUM_W  = ACC_W + LANE_W + 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t                  state_q, state_d;
   logic [BEAT_W-1:0]       beat_q, beat_d;
   logic [2:0]              drain_q, drain_d;
   logic [ROM_LAT-1:0]      vpipe_q, vpipe_d;
   logic [ACC_W-1:0]        acc_q, acc_d;
   logic                    run_ovf_q, run_ovf_d;
   logic [15:0]             cnt_q, cnt_d;
   logic [LANES*A_AW-1:0]   a_addr_q, a_addr_d;
   logic [LANES*B_AW-1:0]   b_addr_q, b_addr_d;
   logic                    busy_q, busy_d;
   logic                    done_q, done_d;
   logic [ACC_W-1:0]        result_q, result_d;
   logic                    ovf_q, ovf_d;
   logic [15:0]             cycles_q, cycles_d;

   logic                    load_addr;
   logic                    feed;
   logic [BEAT_W-1:0]       load_beat;
   logic [LANES*A_AW-1:0]   beat_a;
   logic [LANES*B_AW-1:0]   beat_b;
   logic [SUM_W-1:0]        lane_sum;

   // Beat 0 is loaded on the start edge; afterwards each ISSUE edge loads the next beat.
   assign load_beat = (state_q == IDLE) ? '0 : beat_q + BEAT_W'(1);

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      assign beat_a[i*A_AW +: A_AW] = {load_beat, LANE_W'(i)};
      assign beat_b[i*B_AW +: B_AW] = B_AW'({load_beat, LANE_W'(i)});
   end

   always_comb begin
      lane_sum = SUM_W'(acc_q);
      for (int i = 0; i < LANES; i++) begin
         lane_sum = lane_sum + SUM_W'(bus.products[i*PROD_W +: PROD_W]);
      end
   end

   always_comb begin
      state_d   = state_q;
      beat_d    = beat_q;
      drain_d   = drain_q;
      acc_d     = acc_q;
      run_ovf_d = run_ovf_q;
      cnt_d     = cnt_q;
      result_d  = result_q;
      ovf_d     = ovf_q;
      cycles_d  = cycles_q;
      load_addr = 1'b0;
      feed      = 1'b0;

      if (vpipe_q[ROM_LAT-1]) begin
         acc_d = lane_sum[ACC_W-1:0];
         if (|lane_sum[SUM_W-1:ACC_W]) begin
            run_ovf_d = 1'b1;
         end
      end

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_d   = ISSUE;
               beat_d    = '0;
               drain_d   = 3'd0;
               acc_d     = '0;
               run_ovf_d = 1'b0;
               cnt_d     = 16'd0;
               load_addr = 1'b1;
            end
         end
         ISSUE: begin
            cnt_d = cnt_q + 16'd1;
            feed  = 1'b1;
            if (beat_q == '1) begin
               state_d = DRAIN;
               drain_d = 3'd0;
            end else begin
               beat_d    = load_beat;
               load_addr = 1'b1;
            end
         end
         DRAIN: begin
            cnt_d = cnt_q + 16'd1;
            if (drain_q == 3'(ROM_LAT - 1)) begin
               // The final beat lands on this same edge, so publish the updated sums.
               state_d  = DONE;
               result_d = acc_d;
               ovf_d    = run_ovf_d;
               cycles_d = cnt_d;
            end else begin
               drain_d = drain_q + 3'd1;
            end
         end
         default: state_d = IDLE;
      endcase

      vpipe_d = ROM_LAT'({vpipe_q, feed});

      if (bus.abort && (state_q == ISSUE || state_q == DRAIN)) begin
         state_d   = IDLE;
         vpipe_d   = '0;
         load_addr = 1'b0;
         result_d  = result_q;
         ovf_d     = ovf_q;
         cycles_d  = cycles_q;
      end

      a_addr_d = load_addr ? beat_a : a_addr_q;
      b_addr_d = load_addr ? beat_b : b_addr_q;
      busy_d   = (state_d == ISSUE) || (state_d == DRAIN);
      done_d   = (state_d == DONE);
   end

   always_ff @(posedge clock or negedge reset_l) begin
      if (!reset_l) begin
         state_q   <= IDLE;
         beat_q    <= '0;
         drain_q   <= 3'd0;
         vpipe_q   <= '0;
         acc_q     <= '0;
         run_ovf_q <= 1'b0;
         cnt_q     <= 16'd0;
         a_addr_q  <= '0;
         b_addr_q  <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         result_q  <= '0;
         ovf_q     <= 1'b0;
         cycles_q  <= 16'd0;
      end else begin
         state_q   <= state_d;
         beat_q    <= beat_d;
         drain_q   <= drain_d;
         vpipe_q   <= vpipe_d;
         acc_q     <= acc_d;
         run_ovf_q <= run_ovf_d;
         cnt_q     <= cnt_d;
         a_addr_q  <= a_addr_d;
         b_addr_q  <= b_addr_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         result_q  <= result_d;
         ovf_q     <= ovf_d;
         cycles_q  <= cycles_d;
      end
   end

   assign bus.a_addr = a_addr_q;
   assign bus.b_addr = b_addr_q;
   assign bus.busy   = busy_q;
   assign bus.done   = done_q;
   assign bus.result = result_q;
   assign bus.ovf    = ovf_q;
   assign bus.cycles = cycles_q;

endmodule

`default_nettype wire

// File: tb/tb_mac_sequencer.sv
// ---------------------------------------------------------------------------
// tb_mac_sequencer : directed bench for mac_sequencer with ROM_LAT=1 and ROM_LAT=3 instances (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mac_sequencer;

   localparam int LANES  = 16;
   localparam int A_AW   = 12;
   localparam int B_AW   = 6;
   localparam int PROD_W = 16;
   localparam int ACC_W  = 16;
   localparam int NB     = 256;

   logic clock = 1'b0;
   logic reset_l;
   always #5 clock = ~clock;

   mac_sequencer_if #(.LANES(LANES), .A_AW(A_AW), .B_AW(B_AW), .PROD_W(PROD_W), .ACC_W(ACC_W)) if1 ();
   mac_sequencer_if #(.LANES(LANES), .A_AW(A_AW), .B_AW(B_AW), .PROD_W(PROD_W), .ACC_W(ACC_W)) if3 ();

   mac_sequencer #(.LANES(LANES), .A_AW(A_AW), .B_AW(B_AW), .PROD_W(PROD_W), .ACC_W(ACC_W), .ROM_LAT(1))
      dut1 (.clock(clock), .reset_l(reset_l), .bus(if1.slave));
   mac_sequencer #(.LANES(LANES), .A_AW(A_AW), .B_AW(B_AW), .PROD_W(PROD_W), .ACC_W(ACC_W), .ROM_LAT(3))
      dut3 (.clock(clock), .reset_l(reset_l), .bus(if3.slave));

   // ROM model: mode 0 -> A[i]=1, mode 1 -> A[i]=i mod 256; B[j]=1 always.
   logic mode;
   logic sel;
   logic [LANES*A_AW-1:0]   a1_dly, a3_s0, a3_s1, a3_s2;
   logic [LANES*PROD_W-1:0] p1, p3;
   logic [7:0]              av1, av3;

   always_ff @(posedge clock) begin
      a1_dly <= if1.a_addr;
      a3_s0  <= if3.a_addr;
      a3_s1  <= a3_s0;
      a3_s2  <= a3_s1;
   end

   always_comb begin
      p1  = '0;
      av1 = 8'd0;
      for (int i = 0; i < LANES; i++) begin
         av1 = mode ? a1_dly[i*A_AW +: 8] : 8'd1;
         p1[i*PROD_W +: PROD_W] = {8'd0, av1} * 16'd1;
      end
   end

   always_comb begin
      p3  = '0;
      av3 = 8'd0;
      for (int i = 0; i < LANES; i++) begin
         av3 = mode ? a3_s2[i*A_AW +: 8] : 8'd1;
         p3[i*PROD_W +: PROD_W] = {8'd0, av3} * 16'd1;
      end
   end

   assign if1.products = p1;
   assign if3.products = p3;

   logic                  m_busy, m_done, m_ovf;
   logic [15:0]           m_res, m_cyc, m_acc;
   logic [LANES*A_AW-1:0] m_a;
   logic [LANES*B_AW-1:0] m_b;

   always_comb begin
      if (sel) begin
         m_busy = if3.busy; m_done = if3.done; m_ovf = if3.ovf;
         m_res  = if3.result; m_cyc = if3.cycles; m_acc = dut3.acc_q;
         m_a    = if3.a_addr; m_b = if3.b_addr;
      end else begin
         m_busy = if1.busy; m_done = if1.done; m_ovf = if1.ovf;
         m_res  = if1.result; m_cyc = if1.cycles; m_acc = dut1.acc_q;
         m_a    = if1.a_addr; m_b = if1.b_addr;
      end
   end

   int nchk = 0;
   int nerr = 0;
   int r_done_c, r_done_n, r_busy_err, r_done_err, r_addr_err;
   logic [15:0] r_res, r_cyc;
   logic        r_ovf;

   task automatic chk(input string tag, input longint obs, input longint exp);
      nchk++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic drive(input bit s, input bit st, input bit ab);
      if (s) begin
         if3.start = st; if3.abort = ab;
      end else begin
         if1.start = st; if1.abort = ab;
      end
   endtask

   // One run: start in cycle 0, observe cycles 1..last_c at negedges.
   task automatic do_run(input bit s, input int abort_c, input bit ign, input int last_c);
      int lat, lastb, lastiss, bt, ea;
      sel        = s;
      lat        = s ? 3 : 1;
      lastb      = (abort_c > 0) ? abort_c : NB + lat;
      lastiss    = (abort_c > 0) ? abort_c : NB;
      r_done_c   = -1; r_done_n = 0;
      r_busy_err = 0;  r_done_err = 0; r_addr_err = 0;
      @(negedge clock);
      drive(s, 1'b1, 1'b0);
      for (int c = 1; c <= last_c; c++) begin
         @(negedge clock);
         if (m_busy !== (c <= lastb)) r_busy_err++;
         if (m_done !== (abort_c < 0 && c == NB + lat + 1)) r_done_err++;
         if (m_done === 1'b1) begin
            r_done_n++;
            if (r_done_c < 0) r_done_c = c;
            r_res = m_res; r_cyc = m_cyc; r_ovf = m_ovf;
         end
         bt = ((c <= lastiss) ? c : lastiss) - 1;
         for (int i = 0; i < LANES; i++) begin
            ea = bt * LANES + i;
            if (m_a[i*A_AW +: A_AW] !== ea[A_AW-1:0]) r_addr_err++;
            if (m_b[i*B_AW +: B_AW] !== ea[B_AW-1:0]) r_addr_err++;
         end
         if (!s && abort_c < 0 && c == 6) begin
            chk("a_addr_b5_l3", m_a[3*A_AW +: A_AW], 83);
            chk("b_addr_b5_l3", m_b[3*B_AW +: B_AW], 19);
         end
         if (!s && abort_c < 0 && c == 256) begin
            chk("a_addr_b255_l15", m_a[15*A_AW +: A_AW], 4095);
            chk("b_addr_b255_l15", m_b[15*B_AW +: B_AW], 63);
         end
         if (!mode && abort_c < 0 && c == 1 + lat) chk("acc_before_first", m_acc, 0);
         if (!mode && abort_c < 0 && c == 2 + lat) chk("acc_first_beat", m_acc, 16);
         drive(s, ign && (c == 100 || c == 258), c == abort_c);
      end
   endtask

   task automatic post(input string t, input int edc, input int eres, input int eovf, input int ecyc);
      chk({t, "_done_cycle"}, r_done_c, edc);
      chk({t, "_done_count"}, r_done_n, 1);
      chk({t, "_result"}, r_res, eres);
      chk({t, "_ovf"}, r_ovf, eovf);
      chk({t, "_cycles"}, r_cyc, ecyc);
      chk({t, "_busy_profile_errs"}, r_busy_err, 0);
      chk({t, "_done_profile_errs"}, r_done_err, 0);
      chk({t, "_addr_errs"}, r_addr_err, 0);
   endtask

   initial begin
      reset_l   = 1'b0;
      mode      = 1'b0;
      sel       = 1'b0;
      if1.start = 1'b0; if1.abort = 1'b0;
      if3.start = 1'b0; if3.abort = 1'b0;
      @(negedge clock);
      chk("rst_busy", if1.busy, 0);
      chk("rst_done", if1.done, 0);
      chk("rst_result", if1.result, 0);
      chk("rst_cycles", if3.cycles, 0);
      chk("rst_a_addr", if1.a_addr, 0);
      reset_l = 1'b1;

      do_run(1'b0, -1, 1'b0, 262);
      post("ones_lat1", 258, 16'h1000, 0, 257);
      chk("ones_lat1_result_held", if1.result, 16'h1000);

      mode = 1'b1;
      do_run(1'b0, -1, 1'b0, 262);
      post("ramp_lat1", 258, 16'hF800, 1, 257);

      mode = 1'b0;
      do_run(1'b1, -1, 1'b0, 264);
      post("ones_lat3", 260, 16'h1000, 0, 259);

      do_run(1'b0, 100, 1'b0, 105);
      chk("abort_done_count", r_done_n, 0);
      chk("abort_busy_profile_errs", r_busy_err, 0);
      chk("abort_done_profile_errs", r_done_err, 0);
      chk("abort_addr_errs", r_addr_err, 0);
      chk("abort_result_kept", if1.result, 16'hF800);
      chk("abort_ovf_kept", if1.ovf, 1);
      chk("abort_cycles_kept", if1.cycles, 257);

      do_run(1'b0, -1, 1'b0, 262);
      post("restart", 258, 16'h1000, 0, 257);

      // Reset asserted mid-run, checked before any clock edge.
      sel = 1'b0;
      @(negedge clock);
      if1.start = 1'b1;
      for (int c = 1; c <= 50; c++) begin
         @(negedge clock);
         if1.start = 1'b0;
      end
      chk("pre_reset_busy", if1.busy, 1);
      reset_l = 1'b0;
      #1;
      chk("async_rst_busy", if1.busy, 0);
      chk("async_rst_a_addr", if1.a_addr, 0);
      chk("async_rst_b_addr", if1.b_addr, 0);
      chk("async_rst_result", if1.result, 0);
      chk("async_rst_cycles", if1.cycles, 0);
      chk("async_rst_lat3_result", if3.result, 0);
      @(negedge clock);
      @(negedge clock);
      reset_l = 1'b1;

      // start held through DONE (ignored) into the following IDLE cycle.
      do_run(1'b0, -1, 1'b1, 258);
      post("b2b_first", 258, 16'h1000, 0, 257);
      do_run(1'b0, -1, 1'b0, 262);
      post("b2b_second", 258, 16'h1000, 0, 257);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule

`default_nettype wire
